axil_register_responder: RTL and testbench
==========================================

AXIL_REGISTER_RESPONDER -- requirements
Module: axil_register_responder

Interface
REQ-001 SHALL have parameter N_REGS, default 16, giving the number of 32-bit register words decoded (minimum 3).
REQ-002 SHALL have parameter W_ADDR, default 12, giving the AXI4-Lite address width.
REQ-003 SHALL have parameter ID_VALUE, default 32'h4E49_4331, giving the value of the read-only ID word.
REQ-004 axil_aclk  in  1  sole clock; all logic is on its rising edge.
REQ-005 axil_aresetn  in  1  reset, asynchronous and active-low.
REQ-006 s_axil_awvalid/awready  in/out  1/1, s_axil_awaddr  in  W_ADDR  write address channel.
REQ-007 s_axil_wvalid/wready  in/out  1/1, s_axil_wdata  in  32, s_axil_wstrb  in  4  write data channel.
REQ-008 s_axil_bvalid/bready  out/in  1/1, s_axil_bresp  out  2  write response channel.
REQ-009 s_axil_arvalid/arready  in/out  1/1, s_axil_araddr  in  W_ADDR  read address channel.
REQ-010 s_axil_rvalid/rready  out/in  1/1, s_axil_rdata  out  32, s_axil_rresp  out  2  read data channel.

Function
REQ-011 Word index SHALL be addr[W_ADDR-1:2]; addr[1:0] SHALL be ignored.
REQ-012 Map: index 0 = ID_VALUE (RO); index 1 = cycle counter (RO); indices 2..N_REGS-1 = scratch (RW); index >= N_REGS = unmapped.
REQ-013 Cycle counter SHALL be 32 bits, increment every cycle after reset, and wrap from FFFF_FFFF to 0.
REQ-014 AW and W SHALL be accepted independently and in either order; awready is high iff no address is held and bvalid is low; wready likewise for data.
REQ-015 A write SHALL commit in the first cycle both address and data are held; bvalid SHALL assert the following cycle.
REQ-016 When AW and W handshake in the same cycle, bvalid SHALL assert exactly 2 cycles after the handshake edge.
REQ-017 Scratch writes SHALL update only byte lanes whose wstrb bit is 1; wstrb=0 SHALL write nothing but respond OKAY.
REQ-018 Writes to index 0 or 1 SHALL be ignored and respond OKAY (2'b00); writes to unmapped indices SHALL be ignored and respond SLVERR (2'b10).
REQ-019 bvalid/bresp SHALL hold stable until the bready handshake; the held address and data SHALL clear in that cycle.
REQ-020 Read FSM states: R_IDLE (arready=1) -> R_RESP on the AR handshake; R_RESP (rvalid=1) -> R_IDLE on rready.
REQ-021 rdata SHALL be sampled in the AR handshake cycle and held stable until the rready handshake; read latency is 1 cycle.
REQ-022 Unmapped reads SHALL return rdata=0 and rresp=SLVERR; mapped reads SHALL return OKAY.
REQ-023 If a write commits in the same cycle as an AR handshake to the same word, the read SHALL return the pre-write value.
REQ-024 Read and write paths SHALL operate concurrently with no mutual stall; each has at most one transaction outstanding.

Reset
REQ-025 While axil_aresetn=0: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, counter=0, scratch=0, held address/data cleared, FSM=R_IDLE.
REQ-026 Ready outputs SHALL first assert in the cycle after reset deasserts.
REQ-027 Reset asserted mid-transaction SHALL abort it; no pending response SHALL be presented after reset.

Structure
REQ-028 Response codes (OKAY, SLVERR), fixed word indices (ID, COUNTER, first scratch) and ID_VALUE default SHALL live in the shared simulation tools package.
REQ-029 AW/W pairing (holding registers, readies, commit pulse) SHALL be a sub-module named axil_write_join; all else is in the top.

Verification
REQ-030 Read 0x000 then 0x004 back-to-back with rready held high -> 4E494331/OKAY, then a counter value greater than 0/OKAY.
REQ-031 W (DEADBEEF, strb F) three cycles before AW 0x008, then read 0x008 -> one B with OKAY; read returns DEADBEEF.
REQ-032 Write 0x00C=FFFFFFFF, then 0x00C=00000012 with strb 0001 -> read 0x00C returns FFFFFF12.
REQ-033 Write to and read from 0x040 with N_REGS=16 -> bresp SLVERR, rresp SLVERR, rdata 0, no register changes.
REQ-034 Hold bready/rready low for 10 cycles -> bvalid/bresp and rvalid/rdata stable throughout; awready, wready and arready low until the handshake.
REQ-035 Assert reset with a W held and rvalid high -> all outputs at reset values, no stray B or R after release, scratch registers read 0.

Source files
------------

// File: rtl/axil_register_responder_pkg.sv
// Shared constants, types and helpers for the AXI4-Lite register responder.
// Holds response codes, fixed word indices and the default ID word.
package axil_register_responder_pkg;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [1:0]  RESP_SLVERR      = 2'b10;

    localparam int unsigned IDX_ID           = 32'd0;
    localparam int unsigned IDX_COUNTER      = 32'd1;
    localparam int unsigned IDX_SCRATCH0     = 32'd2;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4E49_4331;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_write_join.sv
// Pairs independently arriving AW and W beats; emits one commit pulse per pair
// and keeps both held until the write response is accepted.
module axil_write_join #(
    parameter int unsigned W_ADDR = 32'd12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [W_ADDR-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              bvalid,
    input  logic              bready,
    output logic [W_ADDR-1:0] addr,
    output logic [31:0]       data,
    output logic [3:0]        strb,
    output logic              commit
);

    logic              ready_en_r;
    logic              aw_held_r;
    logic              w_held_r;
    logic              committed_r;
    logic              commit_r;
    logic [W_ADDR-1:0] addr_r;
    logic [31:0]       data_r;
    logic [3:0]        strb_r;

    // ready_en_r keeps the readies low until the first cycle after reset release
    assign awready = ready_en_r & ~aw_held_r & ~bvalid;
    assign wready  = ready_en_r & ~w_held_r & ~bvalid;
    assign addr    = addr_r;
    assign data    = data_r;
    assign strb    = strb_r;
    assign commit  = commit_r;

    // Holding registers, pairing state and the registered commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r  <= 1'b0;
            aw_held_r   <= 1'b0;
            w_held_r    <= 1'b0;
            committed_r <= 1'b0;
            commit_r    <= 1'b0;
            addr_r      <= '0;
            data_r      <= 32'd0;
            strb_r      <= 4'd0;
        end else begin
            ready_en_r <= 1'b1;
            if (bvalid && bready) begin
                aw_held_r   <= 1'b0;
                w_held_r    <= 1'b0;
                committed_r <= 1'b0;
                commit_r    <= 1'b0;
                addr_r      <= '0;
                data_r      <= 32'd0;
                strb_r      <= 4'd0;
            end else begin
                if (awvalid && awready) begin
                    aw_held_r <= 1'b1;
                    addr_r    <= awaddr;
                end
                if (wvalid && wready) begin
                    w_held_r <= 1'b1;
                    data_r   <= wdata;
                    strb_r   <= wstrb;
                end
                commit_r <= aw_held_r & w_held_r & ~committed_r;
                if (aw_held_r && w_held_r) begin
                    committed_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axil_register_responder.sv
// AXI4-Lite slave exposing an ID word, a free-running cycle counter and
// byte-writable scratch words; reads and writes proceed independently.
module axil_register_responder
    import axil_register_responder_pkg::*;
#(
    parameter int unsigned N_REGS   = 32'd16,
    parameter int unsigned W_ADDR   = 32'd12,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic              axil_aclk,
    input  logic              axil_aresetn,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [W_ADDR-1:0] s_axil_awaddr,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    output logic [1:0]        s_axil_bresp,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    input  logic [W_ADDR-1:0] s_axil_araddr,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp
);

    logic [W_ADDR-1:0] waddr_s;
    logic [31:0]       wdata_s;
    logic [3:0]        wstrb_s;
    logic              commit_s;
    logic [31:0]       widx_s;
    logic [31:0]       ridx_s;
    logic              w_mapped_s;
    logic [31:0]       rd_word_s;
    logic [1:0]        rd_resp_s;
    logic              unused_addr_bits_s;

    logic [31:0]       counter_r;
    logic [31:0]       scratch_r [IDX_SCRATCH0:N_REGS-1];
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    rd_state_e         rd_state_r;
    logic              arready_r;
    logic              rvalid_r;
    logic [31:0]       rdata_r;
    logic [1:0]        rresp_r;

    axil_write_join #(.W_ADDR(W_ADDR)) u_write_join (
        .clk     (axil_aclk),
        .rst_n   (axil_aresetn),
        .awvalid (s_axil_awvalid),
        .awready (s_axil_awready),
        .awaddr  (s_axil_awaddr),
        .wvalid  (s_axil_wvalid),
        .wready  (s_axil_wready),
        .wdata   (s_axil_wdata),
        .wstrb   (s_axil_wstrb),
        .bvalid  (bvalid_r),
        .bready  (s_axil_bready),
        .addr    (waddr_s),
        .data    (wdata_s),
        .strb    (wstrb_s),
        .commit  (commit_s)
    );

    // Byte offset bits never take part in decode.
    assign widx_s             = 32'(waddr_s[W_ADDR-1:2]);
    assign ridx_s             = 32'(s_axil_araddr[W_ADDR-1:2]);
    assign w_mapped_s         = (widx_s < N_REGS);
    assign unused_addr_bits_s = ^{waddr_s[1:0], s_axil_araddr[1:0]};

    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = bresp_r;
    assign s_axil_arready = arready_r;
    assign s_axil_rvalid  = rvalid_r;
    assign s_axil_rdata   = rdata_r;
    assign s_axil_rresp   = rresp_r;

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            counter_r <= 32'd0;
        end else begin
            counter_r <= counter_r + 32'd1;
        end
    end

    // Scratch storage; ID and counter words ignore writes.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            for (int unsigned i = IDX_SCRATCH0; i < N_REGS; i++) begin
                scratch_r[i] <= 32'd0;
            end
        end else begin
            for (int unsigned i = IDX_SCRATCH0; i < N_REGS; i++) begin
                if (commit_s && (widx_s == i)) begin
                    scratch_r[i] <= merge_bytes(scratch_r[i], wdata_s, wstrb_s);
                end
            end
        end
    end

    // Write response: raised the cycle after commit, held until accepted.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            bvalid_r <= 1'b0;
            bresp_r  <= 2'b00;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= w_mapped_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_r && s_axil_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    // Read decode of the word addressed by araddr.
    always_comb begin
        rd_word_s = 32'd0;
        rd_resp_s = RESP_SLVERR;
        if (ridx_s == IDX_ID) begin
            rd_word_s = ID_VALUE;
            rd_resp_s = RESP_OKAY;
        end else if (ridx_s == IDX_COUNTER) begin
            rd_word_s = counter_r;
            rd_resp_s = RESP_OKAY;
        end else if (ridx_s < N_REGS) begin
            rd_resp_s = RESP_OKAY;
            for (int unsigned i = IDX_SCRATCH0; i < N_REGS; i++) begin
                rd_word_s = (ridx_s == i) ? scratch_r[i] : rd_word_s;
            end
        end else begin
            rd_word_s = 32'd0;
            rd_resp_s = RESP_SLVERR;
        end
    end

    // Read FSM; a same-edge write is not yet visible, so reads see the old value.
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
            rresp_r    <= 2'b00;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (arready_r && s_axil_arvalid) begin
                        rd_state_r <= R_RESP;
                        arready_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rdata_r    <= rd_word_s;
                        rresp_r    <= rd_resp_s;
                    end else begin
                        arready_r  <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        rd_state_r <= R_IDLE;
                        arready_r  <= 1'b1;
                        rvalid_r   <= 1'b0;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_register_responder.sv
// Directed scoreboard bench for axil_register_responder: stimulus pushes the
// expected B/R responses, a negedge monitor pops and compares them.
module tb_axil_register_responder;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          nonzero_only;
    } r_exp_t;

    logic        clk;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic [1:0]  bq [$];
    r_exp_t      rq [$];
    logic [1:0]  mon_b;
    r_exp_t      mon_r;
    int          total = 0;
    int          bad   = 0;

    axil_register_responder dut (
        .axil_aclk      (clk),
        .axil_aresetn   (rst_n),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_awaddr  (awaddr),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_bresp   (bresp),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_araddr  (araddr),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_awready"}, 32'(awready), 32'd0);
        chk({tag, "_wready"},  32'(wready),  32'd0);
        chk({tag, "_arready"}, 32'(arready), 32'd0);
        chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
        chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
        chk({tag, "_bresp"},   32'(bresp),   32'd0);
        chk({tag, "_rresp"},   32'(rresp),   32'd0);
        chk({tag, "_rdata"},   rdata,        32'd0);
    endtask

    // Monitor: every accepted B or R beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stray_b: got bresp %h, required no response", bresp);
                end else begin
                    mon_b = bq.pop_front();
                    chk("bresp", 32'(bresp), 32'(mon_b));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stray_r: got rdata %h, required no response", rdata);
                end else begin
                    mon_r = rq.pop_front();
                    if (mon_r.nonzero_only) begin
                        total++;
                        if (rdata == 32'd0 || rresp != 2'b00) begin
                            bad++;
                            $display("FAIL rdata_counter: got %h/%h required nonzero/0", rdata, rresp);
                        end
                    end else begin
                        chk("rdata", rdata, mon_r.data);
                        chk("rresp", 32'(rresp), 32'(mon_r.resp));
                    end
                end
            end
        end
    end

    task automatic do_aw(input logic [11:0] addr);
        int n;
        n = 0;
        awaddr  = addr;
        awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 100) begin n++; @(negedge clk); end
        if (!awready) begin total++; bad++; $display("FAIL aw_timeout: got no awready, required handshake"); end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 100) begin n++; @(negedge clk); end
        if (!wready) begin total++; bad++; $display("FAIL w_timeout: got no wready, required handshake"); end
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [11:0] addr);
        int n;
        n = 0;
        araddr  = addr;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 100) begin n++; @(negedge clk); end
        if (!arready) begin total++; bad++; $display("FAIL ar_timeout: got no arready, required handshake"); end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(posedge clk); n++;
        end
        @(posedge clk); #1;
        total++;
        if (bq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d B / %0d R pending, required 0", name, bq.size(), rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] resp);
        bq.push_back(resp);
        fork
            do_aw(addr);
            do_w(d, s);
        join
        wait_drain("wr");
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] d, input logic [1:0] resp);
        rq.push_back('{data: d, resp: resp, nonzero_only: 1'b0});
        do_ar(addr);
        wait_drain("rd");
    endtask

    initial begin
        int n;
        rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = 12'd0; araddr = 12'd0; wdata = 32'd0; wstrb = 4'd0;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_reset("reset");

        // Readies stay low in the release cycle, rise after the next edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_awready", 32'(awready), 32'd0);
        chk("rel_arready", 32'(arready), 32'd0);
        @(posedge clk); #1;
        chk("first_awready", 32'(awready), 32'd1);
        chk("first_wready",  32'(wready),  32'd1);
        chk("first_arready", 32'(arready), 32'd1);

        // ID then counter, back to back
        rq.push_back('{data: 32'h4E49_4331, resp: 2'b00, nonzero_only: 1'b0});
        rq.push_back('{data: 32'd0,         resp: 2'b00, nonzero_only: 1'b1});
        do_ar(12'h000);
        do_ar(12'h004);
        wait_drain("id_cnt");

        // W three cycles ahead of AW
        bq.push_back(2'b00);
        do_w(32'hDEAD_BEEF, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        do_aw(12'h008);
        wait_drain("w_first");
        rd(12'h008, 32'hDEAD_BEEF, 2'b00);

        // Byte lanes
        wr(12'h00C, 32'hFFFF_FFFF, 4'hF, 2'b00);
        wr(12'h00C, 32'h0000_0012, 4'h1, 2'b00);
        rd(12'h00C, 32'hFFFF_FF12, 2'b00);
        rd(12'h00E, 32'hFFFF_FF12, 2'b00);
        wr(12'h014, 32'hAABB_CCDD, 4'hA, 2'b00);
        rd(12'h014, 32'hAA00_CC00, 2'b00);
        wr(12'h014, 32'h1234_5678, 4'h0, 2'b00);
        rd(12'h014, 32'hAA00_CC00, 2'b00);

        // Read-only words accept writes with OKAY and keep their values
        wr(12'h000, 32'h0000_0000, 4'hF, 2'b00);
        rd(12'h000, 32'h4E49_4331, 2'b00);
        wr(12'h004, 32'h0000_0000, 4'hF, 2'b00);
        rq.push_back('{data: 32'd0, resp: 2'b00, nonzero_only: 1'b1});
        do_ar(12'h004);
        wait_drain("cnt_after_wr");

        // Last mapped word and first unmapped word
        wr(12'h03C, 32'h5A5A_5A5A, 4'hF, 2'b00);
        rd(12'h03C, 32'h5A5A_5A5A, 2'b00);
        wr(12'h040, 32'h1111_1111, 4'hF, 2'b10);
        rd(12'h040, 32'h0000_0000, 2'b10);
        rd(12'hFFC, 32'h0000_0000, 2'b10);
        rd(12'h008, 32'hDEAD_BEEF, 2'b00);
        rd(12'h03C, 32'h5A5A_5A5A, 2'b00);

        // Same-cycle AW/W: bvalid two edges later; an AR at that commit edge sees the old value
        wr(12'h018, 32'hCAFE_F00D, 4'hF, 2'b00);
        bq.push_back(2'b00);
        rq.push_back('{data: 32'hCAFE_F00D, resp: 2'b00, nonzero_only: 1'b0});
        awaddr = 12'h018; wdata = 32'h1122_3344; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("lat_e0_bvalid", 32'(bvalid), 32'd0);
        araddr = 12'h018; arvalid = 1'b1;
        @(posedge clk); #1;
        chk("lat_e1_bvalid", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("lat_e2_bvalid", 32'(bvalid), 32'd1);
        wait_drain("overlap");
        rd(12'h018, 32'h1122_3344, 2'b00);

        // Back-pressure on both response channels
        bready = 1'b0; rready = 1'b0;
        bq.push_back(2'b00);
        rq.push_back('{data: 32'h4E49_4331, resp: 2'b00, nonzero_only: 1'b0});
        fork
            do_aw(12'h01C);
            do_w(32'h0BAD_F00D, 4'hF);
            do_ar(12'h000);
        join
        n = 0;
        while (!(bvalid && rvalid) && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_bvalid",  32'(bvalid),  32'd1);
            chk("stall_bresp",   32'(bresp),   32'd0);
            chk("stall_rvalid",  32'(rvalid),  32'd1);
            chk("stall_rdata",   rdata,        32'h4E49_4331);
            chk("stall_awready", 32'(awready), 32'd0);
            chk("stall_wready",  32'(wready),  32'd0);
            chk("stall_arready", 32'(arready), 32'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1; rready = 1'b1;
        wait_drain("stall");
        rd(12'h01C, 32'h0BAD_F00D, 2'b00);

        // Reset with a W held and an R pending
        wr(12'h020, 32'h7777_7777, 4'hF, 2'b00);
        rready = 1'b0;
        do_ar(12'h020);
        do_w(32'h9999_9999, 4'hF);
        @(posedge clk); #1;
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        chk("pre_rst_wready", 32'(wready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outputs_reset("mid_rst");
        rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_bvalid", 32'(bvalid), 32'd0);
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);
        rd(12'h020, 32'h0000_0000, 2'b00);
        rd(12'h008, 32'h0000_0000, 2'b00);
        rd(12'h000, 32'h4E49_4331, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
